writeback: RTL
==============

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter DEPTH, default 4: per-lane FIFO depth in entries, a power of two and at least 2.
REQ-002 Parameter ADDR_W, default 10: memory address width; each lane owns a region of 2^(ADDR_W-2) words.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 val_write  input  4  per-lane write strobe; bit i writes lane i.
REQ-006 val_in  input  32  lane data; lane i uses bits [8i+7:8i].
REQ-007 full  output  4  per-lane FIFO full flag, combinational from the lane count.
REQ-008 mem_we  output  1  memory write enable, registered.
REQ-009 mem_addr  output  ADDR_W  memory write address, registered.
REQ-010 mem_data  output  8  memory write data, registered.
REQ-011 idle  output  1  high when all four FIFOs are empty and mem_we is low.

Function
REQ-012 Lane FIFOs: each lane has an independent DEPTH-entry FIFO of 8-bit values with a write pointer, a read pointer and a count.
REQ-013 Lane write: at an edge where val_write[i]=1 and full[i]=0, lane i stores val_in[8i+7:8i]; the FIFO count goes up by 1 unless the same edge also drains that lane.
REQ-014 Write while full: a strobe with full[i]=1 is dropped even if lane i drains at the same edge; data is not stored and the count does not change.
REQ-015 full[i] is 1 exactly when count_i equals DEPTH.
REQ-016 Arbitration: round-robin over the non-empty lanes; the search starts at last_grant+1 modulo 4; at most one lane is granted per cycle.
REQ-017 Grant: the granted lane pops its head entry at the edge, and last_grant updates to that lane.
REQ-018 Output on grant: at the edge that pops lane g, mem_we goes to 1, mem_data takes the popped value, and mem_addr takes {g[1:0], cnt_g}.
REQ-019 No grant: in a cycle with no non-empty lane, mem_we goes to 0 at the next edge, and mem_addr/mem_data hold their values.
REQ-020 Address counters: cnt_g is an (ADDR_W-2)-bit per-lane counter that increments after each grant of lane g and wraps from all-ones to 0.
REQ-021 Latency: a value written into an empty FIFO at edge N, with no competing lanes, appears on mem_we/mem_addr/mem_data after edge N+1.
REQ-022 Sustained throughput: one memory write per cycle whenever any lane is non-empty.
REQ-023 Bypass: the block has no bypass path; data popped is always data stored at an earlier edge.
REQ-024 Same-edge write and drain on a non-full lane: both take effect and the count is unchanged.
REQ-025 Order: each lane's values reach memory in acceptance order, at consecutive addresses within that lane's region.

Reset
REQ-026 While rst=0, the block asynchronously clears all FIFO pointers and counts, all cnt_i, mem_we, mem_addr and mem_data.
REQ-027 Values after reset: full=4'b0000 and idle=1; last_grant=3, so lane 0 has first priority.
REQ-028 Reset mid-operation: reset discards all buffered entries; no memory write is issued for them after reset releases.
REQ-029 Inputs during reset: val_write is ignored while rst=0.

Verification
REQ-030 Reset then single write: rst low 25 ns then high; lane 0 writes 0xA5 at edge N -> one cycle later mem_we=1, mem_addr=0x000, mem_data=0xA5; next cycle mem_we=0 and idle=1.
REQ-031 All-lane burst: val_write=4'hF for 2 cycles with val_in=0x44332211, then 0x88776655 -> writes occur on 8 consecutive cycles in lane order 0,1,2,3,0,1,2,3; addresses 0x000, 0x100, 0x200, 0x300, 0x001, 0x101, 0x201, 0x301; data 11,22,33,44,55,66,77,88.
REQ-032 Full/drop: lane 2 is written on DEPTH+1 consecutive edges while lanes 0, 1 and 3 are kept busy -> full[2] rises at count 4; the strobe arriving while full is dropped, its value never appears on mem_data, and the sequence has no gap.
REQ-033 Address wrap: 257 writes to lane 1 -> the last write goes to mem_addr=0x100 (cnt_1 wrapped from 0xFF to 0x00).
REQ-034 Reset mid-burst: rst=0 while three lanes each hold 2 entries -> mem_we=0 immediately; after release, full=0 and idle=1, and no stale writes appear within 10 cycles.
REQ-035 Simultaneous write/drain: lane 3 holds 1 entry and is written at the same edge that pops it -> the count stays 1 and the new value is written on the following cycle.

Source files
------------

// File: rtl/writeback.sv
// Four-lane byte writeback: per-lane FIFOs drained round-robin
// into a single registered memory write port.
module writeback #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        val_write,
    input  logic [31:0]       val_in,
    output logic [3:0]        full,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              idle
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = ADDR_W - 2;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [7:0]    store [4][DEPTH];
    logic [PW-1:0] wr_ptr [4];
    logic [PW-1:0] rd_ptr [4];
    logic [PW:0]   count [4];
    logic [CW-1:0] cnt [4];

    logic [1:0] last_grant;
    logic [1:0] gnt;
    logic [1:0] idx;
    logic       gnt_vld;
    logic [3:0] nonempty;
    logic [3:0] push;
    logic [3:0] pop;

    always_comb begin
        full     = '0;
        nonempty = '0;
        push     = '0;
        for (int i = 0; i < 4; i++) begin
            full[i]     = (count[i] == FULL_CNT);
            nonempty[i] = (count[i] != '0);
            push[i]     = val_write[i] & ~full[i];
        end
    end

    // Search order begins just after the previous winner.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = last_grant;
        idx     = last_grant;
        for (int k = 1; k <= 4; k++) begin
            idx = last_grant + 2'(k);
            if (!gnt_vld && nonempty[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < 4; i++) begin
            pop[i] = gnt_vld && (gnt == 2'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                store[i][wr_ptr[i]] <= val_in[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
                cnt[i]    <= '0;
            end
            last_grant <= 2'd3;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + PW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + (PW+1)'(1);
                end else if (pop[i] && !push[i]) begin
                    count[i] <= count[i] - (PW+1)'(1);
                end
            end
            if (gnt_vld) begin
                mem_we     <= 1'b1;
                mem_addr   <= {gnt, cnt[gnt]};
                mem_data   <= store[gnt][rd_ptr[gnt]];
                cnt[gnt]   <= cnt[gnt] + CW'(1);
                last_grant <= gnt;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    assign idle = ~|nonempty & ~mem_we;

endmodule
